// File: rtl/cmp_share_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmp_share_sched: round-robin sharing of one 4-bit compare slice, MSB-first |
// | Build option CMP_SCHED_EARLY_EXIT_EN: stop scanning at first diff. Rev 1.0 |
// +--------------------------------------------------------------------------+
module cmp_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_eq,
  output logic                    rsp_gt,
  output logic                    rsp_lt,
  output logic                    busy
);

  localparam int NIB = WIDTH / 4;
  localparam int XW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [XW-1:0]      r_idx;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_id;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;

  logic [NREQ-1:0]    w_grant;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW-1:0]     w_k;
  logic               w_found;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [3:0]         w_nib_a;
  logic [3:0]         w_nib_b;
  logic               w_nib_gt;
  logic               w_nib_lt;
  logic               w_last;
  logic               w_decided;

  // Round-robin search starts one past the last granted requester.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_k      = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_k = IDW'((int'(r_rr_ptr) + off) % NREQ);
      if (!w_found && req_valid[w_k]) begin
        w_found        = 1'b1;
        w_grant[w_k]   = 1'b1;
        w_gnt_id       = w_k;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_nib_a   = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b   = r_b[{r_idx, 2'b00} +: 4];
  assign w_nib_gt  = (w_nib_a > w_nib_b);
  assign w_nib_lt  = (w_nib_a < w_nib_b);
  assign w_last    = (r_idx == '0);
  assign w_decided = r_gt | r_lt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_next = S_SCAN;
      end
      S_SCAN: begin
`ifdef CMP_SCHED_EARLY_EXIT_EN
        if (w_nib_gt || w_nib_lt || w_last) w_next = S_RESP;
`else
        if (w_last) w_next = S_RESP;
`endif
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_rr_ptr <= IDW'(NREQ - 1);
      r_id     <= '0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_gnt_id;
            r_rr_ptr <= w_gnt_id;
            r_idx    <= XW'(NIB - 1);
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
          end
        end
        S_SCAN: begin
          // First differing nibble decides; later nibbles cannot override it.
          if (!w_decided && (w_nib_gt || w_nib_lt)) begin
            r_gt <= w_nib_gt;
            r_lt <= w_nib_lt;
          end else if (!w_decided && w_last) begin
            r_eq <= 1'b1;
          end
          if (!w_last) r_idx <= r_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_id    = r_id;
  assign rsp_eq    = r_eq;
  assign rsp_gt    = r_gt;
  assign rsp_lt    = r_lt;

endmodule
`default_nettype wire
